// File: rtl/main_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cpu16_pkg -- shared definitions for the 16-bit CPU control path.
//   Opcode constants, ALU-control class encodings (alu_op), PC source
//   encodings (pc_src), instruction class enum and the main control state
//   enum.  Also used by alu_control.
//   Optional build macro: CTRL_ILLEGAL_TRAP_EN adds the ST_TRAP state.
// -----------------------------------------------------------------------------
package cpu16_pkg;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_SW  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_INV = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    localparam logic [1:0] ALU_OP_DP   = 2'b00;
    localparam logic [1:0] ALU_OP_CMP  = 2'b01;
    localparam logic [1:0] ALU_OP_ADDR = 2'b10;

    localparam logic [1:0] PC_SRC_INC  = 2'b00;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;
    localparam logic [1:0] PC_SRC_JMP  = 2'b10;

    typedef enum logic [2:0] {
        CLS_DP      = 3'd0,
        CLS_MEMOP   = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_JUMP    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_class_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        ST_TRAP   = 3'd6
`endif
    } state_e;

    // Conditional branch resolution: BEQ on zero, BNE on non-zero.
    function automatic logic branch_taken(input logic [3:0] op, input logic zero);
        return ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
    endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// -----------------------------------------------------------------------------
// main_control_fsm_if -- bundle between the main controller and the datapath.
//   instr, mem_ready, alu_zero : datapath/memory -> controller
//   alu_op, opcode             : ALU-control class and latched opcode
//   ir_write, pc_write, mem_read, mem_write, reg_write, mem_to_reg, iord
//                              : datapath strobes
//   pc_src                     : PC source select
//   trap                       : illegal-opcode indicator
//   Modports: master = controller, slave = datapath.
// -----------------------------------------------------------------------------
interface main_control_fsm_if #(
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0] instr;
    logic               mem_ready;
    logic               alu_zero;
    logic [1:0]         alu_op;
    logic [3:0]         opcode;
    logic               ir_write;
    logic               pc_write;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               iord;
    logic [1:0]         pc_src;
    logic               trap;

    modport master (
        input  instr, mem_ready, alu_zero,
        output alu_op, opcode, ir_write, pc_write, mem_read, mem_write,
               reg_write, mem_to_reg, iord, pc_src, trap
    );

    modport slave (
        output instr, mem_ready, alu_zero,
        input  alu_op, opcode, ir_write, pc_write, mem_read, mem_write,
               reg_write, mem_to_reg, iord, pc_src, trap
    );
endinterface

// File: rtl/main_control_fsm_decode.sv
// -----------------------------------------------------------------------------
// instr_class_decode -- combinational opcode classifier.
//   opcode      : 4-bit latched opcode
//   instr_class : DP, MEMOP, BRANCH, JUMP or ILLEGAL
// -----------------------------------------------------------------------------
module instr_class_decode
    import cpu16_pkg::*;
(
    input  logic [3:0]   opcode,
    output instr_class_e instr_class
);

    // Map each opcode to its execution class; unlisted opcodes are illegal.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        case (opcode)
            OP_LW, OP_SW:                      instr_class = CLS_MEMOP;
            OP_ADD, OP_SUB, OP_INV, OP_LSL,
            OP_LSR, OP_AND, OP_OR, OP_SLT:     instr_class = CLS_DP;
            OP_BEQ, OP_BNE:                    instr_class = CLS_BRANCH;
            OP_JMP:                            instr_class = CLS_JUMP;
            default:                           instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// -----------------------------------------------------------------------------
// main_control_fsm -- multi-cycle CPU main control state machine.
//   clk : clock, all state changes on rising edge
//   rst : synchronous active-high reset (state IDLE, opcode 0000)
//   bus : main_control_fsm_if.master (instruction/memory handshake in,
//         datapath strobes out)
//   Optional build macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes enter a TRAP
//   state that holds trap=1 until reset; otherwise they execute as no-ops
//   and trap is tied 0.
// -----------------------------------------------------------------------------
module main_control_fsm
    import cpu16_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    main_control_fsm_if.master  bus
);

    state_e       state_r;
    state_e       state_s;
    logic [3:0]   opcode_r;
    logic         capture_s;
    instr_class_e class_s;

    logic [1:0]   alu_op_s;
    logic         ir_write_s;
    logic         pc_write_s;
    logic         mem_read_s;
    logic         mem_write_s;
    logic         reg_write_s;
    logic         mem_to_reg_s;
    logic         iord_s;
    logic [1:0]   pc_src_s;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic         trap_s;
`endif

    instr_class_decode u_decode (
        .opcode      (opcode_r),
        .instr_class (class_s)
    );

    // State and latched-opcode registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            opcode_r <= 4'b0000;
        end else begin
            state_r <= state_s;
            if (capture_s) begin
                opcode_r <= bus.instr[INSTR_W-1 -: 4];
            end else begin
                opcode_r <= opcode_r;
            end
        end
    end

    // Next-state and strobe decode from current state and latched opcode.
    always_comb begin
        state_s      = state_r;
        capture_s    = 1'b0;
        alu_op_s     = ALU_OP_DP;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        iord_s       = 1'b0;
        pc_src_s     = PC_SRC_INC;
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap_s       = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read_s = 1'b1;
                // IR load and PC+2 happen on the cycle the read completes.
                if (bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    capture_s  = 1'b1;
                    state_s    = ST_DECODE;
                end else begin
                    state_s    = ST_FETCH;
                end
            end
            ST_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (class_s == CLS_ILLEGAL) begin
                    state_s = ST_TRAP;
                end else begin
                    state_s = ST_EXEC;
                end
`else
                state_s = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                case (class_s)
                    CLS_DP: begin
                        state_s = ST_WB;
                    end
                    CLS_MEMOP: begin
                        alu_op_s = ALU_OP_ADDR;
                        state_s  = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op_s = ALU_OP_CMP;
                        if (branch_taken(opcode_r, bus.alu_zero)) begin
                            pc_write_s = 1'b1;
                            pc_src_s   = PC_SRC_BR;
                        end else begin
                            pc_write_s = 1'b0;
                        end
                        state_s = ST_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = PC_SRC_JMP;
                        state_s    = ST_FETCH;
                    end
                    // Illegal opcodes fall through as a no-op.
                    default: begin
                        state_s = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                iord_s   = 1'b1;
                alu_op_s = ALU_OP_ADDR;
                if (opcode_r == OP_SW) begin
                    mem_write_s = 1'b1;
                end else begin
                    mem_read_s  = 1'b1;
                end
                if (!bus.mem_ready) begin
                    state_s = ST_MEM;
                end else if (opcode_r == OP_SW) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (opcode_r == OP_LW);
                state_s      = ST_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                trap_s  = 1'b1;
                state_s = ST_TRAP;
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.alu_op     = alu_op_s;
    assign bus.opcode     = opcode_r;
    assign bus.ir_write   = ir_write_s;
    assign bus.pc_write   = pc_write_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.iord       = iord_s;
    assign bus.pc_src     = pc_src_s;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.trap       = trap_s;
`else
    assign bus.trap       = 1'b0;
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_control_fsm -- self-checking bench for main_control_fsm.
// Each instruction is expanded into a per-cycle list of (inputs, expected
// outputs) from the instruction's phase sequence, then replayed against the
// DUT. Don't-care inputs are randomized in every cycle.
// Expected vector packing: {alu_op, opcode, ir_write, pc_write, mem_read,
// mem_write, reg_write, mem_to_reg, iord, pc_src, trap}.
// -----------------------------------------------------------------------------
module tb_main_control_fsm;

    logic clk = 1'b0;
    logic rst;

    main_control_fsm_if #(.INSTR_W(16)) bus ();

    main_control_fsm #(.INSTR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mr;
        logic        az;
        logic [15:0] instr;
        logic [15:0] exp;
        string       tag;
    } step_t;

    step_t      q[$];
    int         checks = 0;
    int         fails  = 0;
    logic [3:0] model_op;

    function automatic logic [15:0] pk(input logic [1:0] alu, input logic [3:0] op,
                                       input logic irw, input logic pcw, input logic mrd,
                                       input logic mwr, input logic rw, input logic m2r,
                                       input logic io, input logic [1:0] pcs, input logic tr);
        return {alu, op, irw, pcw, mrd, mwr, rw, m2r, io, pcs, tr};
    endfunction

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction class straight from the opcode table: 0 DP, 1 MEM, 2 BR, 3 JMP, 4 illegal
    function automatic int cls(input logic [3:0] op);
        if (op <= 4'd1) return 0 + 1;
        else if (op <= 4'd9) return 0;
        else if (op == 4'd11 || op == 4'd12) return 2;
        else if (op == 4'd13) return 3;
        else return 4;
    endfunction

    task automatic add_step(input logic r, input logic mr, input logic az,
                            input logic [15:0] ins, input logic [15:0] exp, input string tag);
        step_t s;
        s.rst = r; s.mr = mr; s.az = az; s.instr = ins; s.exp = exp; s.tag = tag;
        q.push_back(s);
    endtask

    // Expand one instruction starting in FETCH; optionally reset during SW memory wait.
    task automatic add_instr(input logic [3:0] op, input logic az, input int fw,
                             input int mw, input bit abort_mem);
        int  c = cls(op);
        bit  is_lw = (op == 4'd0);
        bit  taken;
        for (int i = 0; i < fw; i++)
            add_step(1'b0, 1'b0, r1(), 16'($urandom), pk(2'b00, model_op, 0,0,1,0,0,0,0, 2'b00, 0), "fetch_wait");
        add_step(1'b0, 1'b1, r1(), {op, 12'($urandom)}, pk(2'b00, model_op, 1,1,1,0,0,0,0, 2'b00, 0), "fetch");
        model_op = op;
        add_step(1'b0, r1(), r1(), 16'($urandom), pk(2'b00, op, 0,0,0,0,0,0,0, 2'b00, 0), "decode");
        case (c)
            0: add_step(1'b0, r1(), r1(), 16'($urandom), pk(2'b00, op, 0,0,0,0,0,0,0, 2'b00, 0), "exec_dp");
            1: add_step(1'b0, r1(), r1(), 16'($urandom), pk(2'b10, op, 0,0,0,0,0,0,0, 2'b00, 0), "exec_mem");
            2: begin
                taken = (op == 4'd11) ? az : !az;
                add_step(1'b0, r1(), az, 16'($urandom),
                         pk(2'b01, op, 0, taken, 0,0,0,0,0, taken ? 2'b01 : 2'b00, 0), "exec_branch");
            end
            3: add_step(1'b0, r1(), r1(), 16'($urandom), pk(2'b00, op, 0,1,0,0,0,0,0, 2'b10, 0), "exec_jmp");
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++)
                    add_step(1'b0, r1(), r1(), 16'($urandom), pk(2'b00, op, 0,0,0,0,0,0,0, 2'b00, 1), "trap_hold");
                add_step(1'b1, r1(), r1(), 16'($urandom), pk(2'b00, op, 0,0,0,0,0,0,0, 2'b00, 1), "trap_rst");
                model_op = 4'd0;
                add_step(1'b0, r1(), r1(), 16'($urandom), 16'h0000, "trap_idle");
`else
                add_step(1'b0, r1(), r1(), 16'($urandom), pk(2'b00, op, 0,0,0,0,0,0,0, 2'b00, 0), "exec_illegal");
`endif
            end
        endcase
        if (c == 1) begin
            for (int i = 0; i < mw; i++)
                add_step(1'b0, 1'b0, r1(), 16'($urandom), pk(2'b10, op, 0,0,is_lw,!is_lw,0,0,1, 2'b00, 0), "mem_wait");
            if (abort_mem) begin
                // Reset collides with mem_ready: reset must win, no writeback follows.
                add_step(1'b1, 1'b1, r1(), 16'($urandom), pk(2'b10, op, 0,0,is_lw,!is_lw,0,0,1, 2'b00, 0), "mem_rst");
                model_op = 4'd0;
                add_step(1'b0, 1'b1, r1(), 16'($urandom), 16'h0000, "mem_rst_idle");
            end else begin
                add_step(1'b0, 1'b1, r1(), 16'($urandom), pk(2'b10, op, 0,0,is_lw,!is_lw,0,0,1, 2'b00, 0), "mem_done");
            end
        end
        if ((c == 0 || (c == 1 && is_lw)) && !abort_mem)
            add_step(1'b0, r1(), r1(), 16'($urandom), pk(2'b00, op, 0,0,0,0,1,is_lw,0, 2'b00, 0), "wb");
    endtask

    task automatic apply_step(input step_t s, output logic [15:0] o);
        @(negedge clk);
        rst = s.rst; bus.mem_ready = s.mr; bus.alu_zero = s.az; bus.instr = s.instr;
        #1;
        o = {bus.alu_op, bus.opcode, bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write,
             bus.reg_write, bus.mem_to_reg, bus.iord, bus.pc_src, bus.trap};
    endtask

    task automatic test_reset();
        step_t s; logic [15:0] o;
        add_step(1'b1, 1'b1, r1(), 16'($urandom), 16'h0000, "reset_hold");
        model_op = 4'd0;
        add_step(1'b0, 1'b1, r1(), 16'($urandom), 16'h0000, "reset_idle");
        add_step(1'b0, 1'b0, r1(), 16'($urandom), pk(2'b00, 4'd0, 0,0,1,0,0,0,0, 2'b00, 0), "reset_fetch");
        while (q.size() > 0) begin
            s = q.pop_front(); apply_step(s, o); checks++;
            if (o !== s.exp) begin fails++; $display("FAIL test_reset.%s: got %h expected %h", s.tag, o, s.exp); end
        end
    endtask

    task automatic test_sub_and_lw();
        step_t s; logic [15:0] o;
        add_instr(4'h3, r1(), 0, 0, 1'b0);
        add_instr(4'h0, r1(), 0, 3, 1'b0);
        add_instr(4'h1, r1(), 1, 0, 1'b0);
        while (q.size() > 0) begin
            s = q.pop_front(); apply_step(s, o); checks++;
            if (o !== s.exp) begin fails++; $display("FAIL test_sub_and_lw.%s: got %h expected %h", s.tag, o, s.exp); end
        end
    endtask

    task automatic test_branch_jump();
        step_t s; logic [15:0] o;
        add_instr(4'hB, 1'b1, 0, 0, 1'b0);
        add_instr(4'hC, 1'b1, 0, 0, 1'b0);
        add_instr(4'hB, 1'b0, 0, 0, 1'b0);
        add_instr(4'hC, 1'b0, 0, 0, 1'b0);
        add_instr(4'hD, r1(), 0, 0, 1'b0);
        while (q.size() > 0) begin
            s = q.pop_front(); apply_step(s, o); checks++;
            if (o !== s.exp) begin fails++; $display("FAIL test_branch_jump.%s: got %h expected %h", s.tag, o, s.exp); end
        end
    endtask

    task automatic test_reset_mid_sw();
        step_t s; logic [15:0] o;
        add_instr(4'h1, r1(), 0, 2, 1'b1);
        add_step(1'b0, 1'b0, r1(), 16'($urandom), pk(2'b00, 4'd0, 0,0,1,0,0,0,0, 2'b00, 0), "post_rst_fetch");
        while (q.size() > 0) begin
            s = q.pop_front(); apply_step(s, o); checks++;
            if (o !== s.exp) begin fails++; $display("FAIL test_reset_mid_sw.%s: got %h expected %h", s.tag, o, s.exp); end
        end
    endtask

    task automatic test_illegal();
        step_t s; logic [15:0] o;
        add_instr(4'hE, r1(), 0, 0, 1'b0);
        add_instr(4'hA, r1(), 0, 0, 1'b0);
        add_instr(4'hF, r1(), 0, 0, 1'b0);
        add_instr(4'h2, r1(), 0, 0, 1'b0);
        while (q.size() > 0) begin
            s = q.pop_front(); apply_step(s, o); checks++;
            if (o !== s.exp) begin fails++; $display("FAIL test_illegal.%s: got %h expected %h", s.tag, o, s.exp); end
        end
    endtask

    task automatic test_random();
        step_t s; logic [15:0] o;
        for (int n = 0; n < 60; n++)
            add_instr(4'($urandom), r1(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        while (q.size() > 0) begin
            s = q.pop_front(); apply_step(s, o); checks++;
            if (o !== s.exp) begin fails++; $display("FAIL test_random.%s: got %h expected %h", s.tag, o, s.exp); end
            checks++;
            if (((bus.mem_read & bus.mem_write) | (bus.reg_write & bus.pc_write)) !== 1'b0) begin
                fails++;
                $display("FAIL test_random.exclusive: got rd=%b wr=%b rw=%b pcw=%b expected no overlap",
                         bus.mem_read, bus.mem_write, bus.reg_write, bus.pc_write);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.instr     = 16'h0000;
        model_op      = 4'd0;
        @(posedge clk);
        test_reset();
        test_sub_and_lw();
        test_branch_jump();
        test_reset_mid_sw();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
